// File: rtl/uart_flash_cmd_if.sv
// uart_flash_cmd_if: receiver, flash and output-stream signals of uart_flash_cmd
interface uart_flash_cmd_if;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_read;
  logic fl_read;
  logic [23:0] fl_addr;
  logic fl_ready;
  logic [7:0] fl_data;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic err;
  modport master (
    input rx_data, rx_valid, fl_ready, fl_data, out_ready,
    output rx_read, fl_read, fl_addr, out_data, out_valid, busy, err
  );
  modport slave (
    output rx_data, rx_valid, fl_ready, fl_data, out_ready,
    input rx_read, fl_read, fl_addr, out_data, out_valid, busy, err
  );
endinterface

// File: rtl/uart_flash_cmd.sv
// uart_flash_cmd: parses "R<6 hex addr><2 hex len><CR>" and streams flash bytes; UART_FLASH_CMD_ABORT_EN enables rx abort mid-stream
module uart_flash_cmd #(
  parameter logic [7:0] CMD_CHAR = 8'h52,
  parameter logic [7:0] TERM_CHAR = 8'h0D
) (
  input logic clk,
  input logic rst,
  uart_flash_cmd_if.master bus
);
  typedef enum logic [2:0] {IDLE, ADDR, LEN, TERM, ISSUE, WAIT, OUT} state_t;
  state_t state;
  logic [23:0] addr;
  logic [8:0] rem;
  logic [2:0] cnt;
  logic take, stream, grab, stop;
  logic [4:0] hx;
  // bit 4 flags a valid hex digit, bits 3:0 carry its value
  function automatic logic [4:0] hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") ? {1'b1, c[3:0]} :
           ((c >= "A" && c <= "F") || (c >= "a" && c <= "f")) ? {1'b1, c[3:0] + 4'd9} : 5'd0;
  endfunction
  assign take = bus.rx_valid && !bus.rx_read;
  assign stream = state inside {ISSUE, WAIT, OUT};
  assign hx = hex(bus.rx_data);
  assign bus.fl_addr = addr;
  assign bus.busy = state != IDLE;
`ifdef UART_FLASH_CMD_ABORT_EN
  logic abort;
  assign grab = take;
  assign stop = abort || take;
  // abort request latched for the rest of the stream, dropped once idle
  always_ff @(posedge clk) begin
    if (rst) abort <= 1'b0;
    else abort <= (abort || take) && stream;
  end
`else
  assign grab = take && !stream;
  assign stop = 1'b0;
`endif
  // command parser and flash streaming FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      cnt <= '0;
      bus.rx_read <= 1'b0;
      bus.fl_read <= 1'b0;
      bus.out_data <= '0;
      bus.out_valid <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.rx_read <= grab;
      bus.fl_read <= 1'b0;
      bus.err <= 1'b0;
      case (state)
        IDLE: if (take && bus.rx_data == CMD_CHAR) begin
          state <= ADDR;
          cnt <= '0;
        end
        ADDR: if (take) begin
          addr <= {addr[19:0], hx[3:0]};
          cnt <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
          state <= !hx[4] ? IDLE : (cnt == 3'd5) ? LEN : ADDR;
          bus.err <= !hx[4];
        end
        LEN: if (take) begin
          rem <= (cnt[0] && {rem[3:0], hx[3:0]} == 8'd0) ? 9'd256 : {1'b0, rem[3:0], hx[3:0]};
          cnt <= cnt + 3'd1;
          state <= !hx[4] ? IDLE : cnt[0] ? TERM : LEN;
          bus.err <= !hx[4];
        end
        TERM: if (take) begin
          state <= (bus.rx_data == TERM_CHAR) ? ISSUE : IDLE;
          bus.err <= bus.rx_data != TERM_CHAR;
        end
        ISSUE: begin
          bus.fl_read <= 1'b1;
          state <= WAIT;
        end
        WAIT: if (bus.fl_ready) begin
          bus.out_data <= bus.fl_data;
          bus.out_valid <= 1'b1;
          state <= OUT;
        end
        OUT: if (bus.out_valid && bus.out_ready) begin
          bus.out_valid <= 1'b0;
          addr <= addr + 24'd1;
          rem <= rem - 9'd1;
          state <= (rem == 9'd1 || stop) ? IDLE : ISSUE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_flash_cmd.sv
// tb_uart_flash_cmd: scoreboard bench for uart_flash_cmd with a latency-programmable flash model
module tb_uart_flash_cmd;
  logic clk, rst;
  uart_flash_cmd_if bus ();
  uart_flash_cmd dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int nfl = 0, nout = 0, nerr = 0;
  int n0, o0, e0;
  int flat = 2, fcnt = 0;
  logic [23:0] fa;
  logic last_busy;
  logic ok;
  logic [23:0] qa[$];
  logic [7:0] qd[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] dat(input logic [23:0] a);
    return (a[7:0] + 8'd1) * 8'h11;
  endfunction
  // flash: answers each fl_read with a one-cycle fl_ready after flat cycles
  initial forever begin
    @(negedge clk);
    bus.fl_ready = 1'b0;
    if (fcnt > 0) begin
      fcnt--;
      if (fcnt == 0) begin
        bus.fl_ready = 1'b1;
        bus.fl_data = dat(fa);
      end
    end
    if (bus.fl_read) begin
      fa = bus.fl_addr;
      fcnt = flat;
    end
  end
  // monitor: compares reads and output handshakes against the queues
  initial forever begin
    @(negedge clk);
    #2;
    if (bus.fl_read) begin
      nfl++;
      chk("fl_q", qa.size() > 0, 1);
      if (qa.size() > 0) chk("fl_addr", bus.fl_addr, qa.pop_front());
    end
    if (bus.out_valid && bus.out_ready) begin
      nout++;
      chk("out_q", qd.size() > 0, 1);
      if (qd.size() > 0) chk("out_data", bus.out_data, qd.pop_front());
    end
    if (bus.err) nerr++;
  end
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    for (int n = 0; n < 400 && !bus.rx_read; n++) @(negedge clk);
    last_busy = bus.busy;
    chk("rx_read", bus.rx_read, 1);
    bus.rx_valid = 1'b0;
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask
  task automatic cmd(input string s);
    send_str(s);
    send_byte(8'h0D);
  endtask
  task automatic expect_run(input logic [23:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      logic [23:0] x;
      x = a + 24'(i);
      qa.push_back(x);
      qd.push_back(dat(x));
    end
  endtask
  task automatic mark();
    n0 = nfl;
    o0 = nout;
    e0 = nerr;
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 4000 && bus.busy; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("idle", bus.busy, 0);
  endtask
  task automatic done_run(input string tag, input int n);
    chk({tag, "_reads"}, nfl - n0, n);
    chk({tag, "_outs"}, nout - o0, n);
    chk({tag, "_qa"}, qa.size(), 0);
    chk({tag, "_qd"}, qd.size(), 0);
    chk({tag, "_err"}, nerr, e0);
  endtask
  task automatic check_rst(input string tag);
    chk({tag, "_rx_read"}, bus.rx_read, 0);
    chk({tag, "_fl_read"}, bus.fl_read, 0);
    chk({tag, "_fl_addr"}, bus.fl_addr, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_err"}, bus.err, 0);
  endtask
  initial begin
    rst = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.fl_ready = 1'b0;
    bus.fl_data = 8'h00;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_rst("reset");
    rst = 1'b0;
    mark();
    expect_run(24'h400000, 3);
    cmd("R40000003");
    wait_idle();
    done_run("basic", 3);
    mark();
    expect_run(24'hFFFFFE, 2);
    cmd("Rfffffe02");
    wait_idle();
    done_run("hi", 2);
    mark();
    expect_run(24'hFFFFFF, 2);
    cmd("RFFFFFF02");
    wait_idle();
    done_run("wrap", 2);
    mark();
    expect_run(24'h400000, 256);
    cmd("R40000000");
    wait_idle();
    done_run("len256", 256);
    mark();
    send_str("x");
    send_byte(8'h0D);
    repeat (3) @(negedge clk);
    chk("garbage_err", nerr, e0);
    chk("garbage_busy", last_busy, 0);
    mark();
    send_str("R4G");
    repeat (3) @(negedge clk);
    chk("bad_addr_err", nerr, e0 + 1);
    chk("bad_addr_busy", bus.busy, 0);
    mark();
    send_str("R1234560Z");
    repeat (3) @(negedge clk);
    chk("bad_len_err", nerr, e0 + 1);
    mark();
    send_str("R12345601X");
    repeat (3) @(negedge clk);
    chk("bad_term_err", nerr, e0 + 1);
    chk("bad_term_reads", nfl, n0);
    mark();
    expect_run(24'h000000, 1);
    cmd("R00000001");
    wait_idle();
    done_run("recover", 1);
    mark();
    bus.out_ready = 1'b0;
    expect_run(24'h001000, 3);
    cmd("R00100003");
    for (int n = 0; n < 100 && !bus.out_valid; n++) @(negedge clk);
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_data !== dat(24'h001000)) ok = 1'b0;
    end
    chk("hold_stable", ok, 1);
    chk("hold_data", bus.out_data, dat(24'h001000));
    chk("hold_no_read", nfl - n0, 1);
    bus.out_ready = 1'b1;
    wait_idle();
    done_run("hold", 3);
    mark();
    flat = 6;
    qa.push_back(24'h002000);
    cmd("R00200001");
    for (int n = 0; n < 50 && nfl == n0; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_rst("midrst");
    rst = 1'b0;
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) ok = 1'b0;
    end
    chk("midrst_ignore", ok, 1);
    chk("midrst_reads", nfl - n0, 1);
    chk("midrst_outs", nout, o0);
    flat = 2;
    mark();
    expect_run(24'h003000, 10);
    cmd("R0030000A");
    for (int n = 0; n < 200 && nfl - n0 < 3; n++) @(negedge clk);
    send_byte("Z");
    wait_idle();
`ifdef UART_FLASH_CMD_ABORT_EN
    chk("abort_len", (nout - o0 >= 3) && (nout - o0 <= 4), 1);
    chk("abort_reads", nfl - n0, nout - o0);
    chk("abort_err", nerr, e0);
    qa.delete();
    qd.delete();
`else
    chk("pend_idle", last_busy, 0);
    done_run("noabort", 10);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
